// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Sits behind the 32x32 multiplier. It sums a programmed number of 65-bit
//   terms {carry_out, product} into an ACC_WIDTH-bit unsigned dot product.
//   Terms come in on a valid/ready port, one per cycle. The finished sum is
//   presented on a valid/ready output port.
//
//   Optional macro ACC_SATURATE_EN:
//     defined   - on overflow the accumulator sticks at all ones.
//     undefined - the accumulator wraps modulo 2^ACC_WIDTH.
//   The overflow flag is sticky in both builds.
//
// Ports
//   clk, reset            clock, async active-high reset
//   start, length         begin an operation of `length` terms (IDLE only)
//   in_valid, in_ready    term handshake
//   product, carry_out    term = {carry_out, product}
//   out_valid, out_ready  result handshake
//   result, overflow      accumulated sum, sticky overflow flag
//   busy                  high in ACCUM and DONE
module dot_product_accumulator #(
  parameter int ACC_WIDTH = 72,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] length,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          product,
  input  logic                 carry_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 overflow,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef logic [ACC_WIDTH:0]   sum_t;
  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef logic [LEN_WIDTH-1:0] len_t;

  state_t state_q;
  acc_t   acc_q, acc_d, result_q;
  len_t   len_q, count_q;
  logic   ovf_q, ovf_d;
  logic   in_ready_q, out_valid_q, busy_q;

  sum_t   term_w, sum_w;
  logic   accept_w, last_w;

  // One extra bit on the sum captures the carry out of bit ACC_WIDTH-1.
  assign term_w   = sum_t'({carry_out, product});
  assign sum_w    = sum_t'(acc_q) + term_w;
  assign accept_w = in_valid && in_ready_q;
  assign last_w   = (count_q == len_q - len_t'(1));

  always_comb begin
    ovf_d = ovf_q | sum_w[ACC_WIDTH];
`ifdef ACC_SATURATE_EN
    // Once saturated, later terms no longer change the sum.
    if (ovf_q || sum_w[ACC_WIDTH]) acc_d = '1;
    else                           acc_d = sum_w[ACC_WIDTH-1:0];
`else
    acc_d = sum_w[ACC_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      result_q    <= '0;
      len_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            len_q   <= length;
            busy_q  <= 1'b1;
            if (length != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              // Empty vector: result is 0, straight to the output handshake.
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= '0;
            end
          end
        end
        ACCUM: begin
          if (accept_w) begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_q + len_t'(1);
            if (last_w) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              result_q    <= acc_d;
            end
          end
        end
        DONE: begin
          // start here is deliberately ignored, even on the handshake cycle.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule
